// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes, fetch FSM states, default constants.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_VALID = 2'b10
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam int          DEF_WAIT_MAX = 15;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] INSTR_NONE   = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC former: sequential, PC-relative branch, region jump, register jump.
module npc_calc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [1:0]  NPCOp,
    input  logic [15:0] Imm16,
    input  logic [25:0] Imm26,
    input  logic [31:0] RD1,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    assign pc4    = PC + PC_STEP;
    assign br_off = {{14{Imm16[15]}}, Imm16, 2'b00};

    // Register jumps are word-forced here; the top decides whether misalignment traps instead.
    always_comb begin
        next_pc = pc4;
        case (npc_op_e'(NPCOp))
            NPC_PLUS4:  next_pc = pc4;
            NPC_BRANCH: next_pc = pc4 + br_off;
            NPC_JUMP:   next_pc = {pc4[31:28], Imm26, 2'b00};
            NPC_JR:     next_pc = RD1 & WORD_MASK;
            default:    next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// PC register and fetch FSM with req/ready instruction memory and timeout re-issue.
// Optional IFETCH_ALIGN_CHK_EN: misaligned register jumps redirect to EXC_VEC and set sticky misalign.
//
//  state   | meaning
//  S_IDLE  | one cycle after reset before the first request
//  S_REQ   | imem_req high at PC; on timeout one cycle with req low, then retry
//  S_VALID | instr/PC presented to decode until advance
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter int          WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  NPCOp,
    input  logic [15:0] Imm16,
    input  logic [25:0] Imm26,
    input  logic [31:0] RD1,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC4,
`ifdef IFETCH_ALIGN_CHK_EN
    output logic        misalign,
`endif
    output logic        fetch_tmo
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, instr_q, next_pc;
    logic [WAIT_W-1:0] wait_q;
    logic              tmo_hit, capture, load_pc;

    npc_calc u_npc (
        .PC      (pc_q),
        .NPCOp   (NPCOp),
        .Imm16   (Imm16),
        .Imm26   (Imm26),
        .RD1     (RD1),
        .next_pc (next_pc)
    );

    assign tmo_hit = (state_q == S_REQ) && (wait_q == WAIT_W'(WAIT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // The timeout cycle itself is the one-cycle request gap before re-issue.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_tmo   = 1'b0;
        capture     = 1'b0;
        load_pc     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (tmo_hit) begin
                    fetch_tmo = 1'b1;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        capture = 1'b1;
                        state_d = S_VALID;
                    end
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (advance) begin
                    load_pc = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            wait_q <= '0;
        else if (state_q != S_REQ)          wait_q <= '0;
        else if (tmo_hit || capture)        wait_q <= '0;
        else                                wait_q <= wait_q + WAIT_W'(1);
    end

`ifdef IFETCH_ALIGN_CHK_EN
    logic misalign_q;
    logic jr_bad;

    assign jr_bad   = (npc_op_e'(NPCOp) == NPC_JR) && (RD1[1:0] != 2'b00);
    assign misalign = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= INSTR_NONE;
            misalign_q <= 1'b0;
        end else begin
            if (capture) instr_q <= imem_rdata;
            if (load_pc) begin
                if (jr_bad) begin
                    pc_q       <= EXC_VEC;
                    misalign_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= INSTR_NONE;
        end else begin
            if (capture) instr_q <= imem_rdata;
            if (load_pc) pc_q    <= next_pc;
        end
    end
`endif

    assign PC        = pc_q;
    assign PC4       = pc_q + PC_STEP;
    assign instr     = instr_q;
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: memory responder with random latency, scoreboard of fetch PCs.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC    = 32'h0000_4180;
    localparam int          WMAX   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  NPCOp;
    logic [15:0] Imm16;
    logic [25:0] Imm26;
    logic [31:0] RD1;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        fetch_tmo;
`ifdef IFETCH_ALIGN_CHK_EN
    logic        misalign;
`endif

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .NPCOp       (NPCOp),
        .Imm16       (Imm16),
        .Imm26       (Imm26),
        .RD1         (RD1),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .PC          (PC),
        .PC4         (PC4),
`ifdef IFETCH_ALIGN_CHK_EN
        .misalign    (misalign),
`endif
        .fetch_tmo   (fetch_tmo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Reference next-PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] op,
                                             input logic [15:0] i16, input logic [25:0] i26,
                                             input logic [31:0] r, output bit mis);
        logic [31:0] link;
        int          off;
        mis  = 1'b0;
        link = pc + 32'd4;
        off  = int'($signed(i16)) * 4;
        case (op)
            2'd0:    return link;
            2'd1:    return link + 32'(off);
            2'd2:    return (link & 32'hF000_0000) + {6'b0, i26} * 32'd4;
            default: begin
`ifdef IFETCH_ALIGN_CHK_EN
                if (r % 4 != 0) begin
                    mis = 1'b1;
                    return EXC;
                end
`endif
                return r - (r % 4);
            end
        endcase
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    bit          mis_model = 1'b0;
    int          fetches_done = 0;
    bit          resp_en = 1'b0, drv_en = 1'b0, mon_en = 1'b0;
    bit          force_fast = 1'b0, force_stall = 1'b0;

    localparam int ND = 9;
    logic [1:0]  dir_op  [ND] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
    logic [15:0] dir_i16 [ND] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 16'h0003, 16'h0, 16'h0};
    logic [25:0] dir_i26 [ND] = '{26'h0000C10, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0};
    logic [31:0] dir_rd1 [ND] = '{32'h0, 32'h3100, 32'h3102, 32'h3008, 32'h0, 32'h3008, 32'h0,
                                  32'hFFFF_FFFC, 32'h0};
    int          dir_idx = 0;

    // Memory responder: random latency, occasional stall that must time out exactly once.
    int cnt = 0, lat = 0, tmo_this = 0;
    bit in_fetch = 1'b0, stall_this = 1'b0;
    always @(negedge clk) begin
        if (resp_en) begin
            if (imem_req) begin
                check("tmo_low_while_req", {31'b0, fetch_tmo}, 32'd0);
                if (!in_fetch) begin
                    in_fetch   = 1'b1;
                    cnt        = 0;
                    tmo_this   = 0;
                    stall_this = !force_fast && (force_stall || ($urandom_range(0, 9) == 0));
                    lat        = stall_this ? 1000 : (force_fast ? 0 : int'($urandom_range(0, 3)));
                    force_fast  = 1'b0;
                    force_stall = 1'b0;
                    check("imem_addr", imem_addr, (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx);
                end
                if (cnt == lat) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    in_fetch   = 1'b0;
                    check("tmo_count", tmo_this, stall_this ? 32'd1 : 32'd0);
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                    cnt++;
                end
            end else begin
                if (fetch_tmo && in_fetch) begin
                    check("tmo_after_wait_max", cnt, WMAX);
                    tmo_this++;
                    cnt = 0;
                    lat = 2;
                end
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
        end
    end

    // Driver: advances while valid, records the model's next fetch address.
    always @(negedge clk) begin
        bit          mis;
        logic [31:0] nxt;
        if (drv_en) begin
            NPCOp = 2'($urandom_range(0, 3));
            Imm16 = 16'($urandom);
            Imm26 = 26'($urandom);
            RD1   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if (instr_valid && (dir_idx < ND || $urandom_range(0, 1) == 1)) begin
                if (dir_idx < ND) begin
                    NPCOp = dir_op[dir_idx];
                    Imm16 = dir_i16[dir_idx];
                    Imm26 = dir_i26[dir_idx];
                    RD1   = dir_rd1[dir_idx];
                    dir_idx++;
                end
                advance = 1'b1;
                nxt     = ref_next(cur_pc, NPCOp, Imm16, Imm26, RD1, mis);
                if (mis) mis_model = 1'b1;
                cur_pc  = nxt;
                exp_q.push_back(nxt);
            end else begin
                advance = instr_valid ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pop on each new valid instruction, check hold while valid.
    bit          prev_valid = 1'b0;
    logic [31:0] held_pc, held_instr, e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid && !prev_valid) begin
                check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("PC", PC, e);
                    check("instr", instr, mem_word(e));
                    check("PC4", PC4, e + 32'd4);
`ifdef IFETCH_ALIGN_CHK_EN
                    check("misalign", {31'b0, misalign}, {31'b0, mis_model});
`endif
                end
                held_pc    = PC;
                held_instr = instr;
                fetches_done++;
            end else if (instr_valid) begin
                check("PC_held", PC, held_pc);
                check("instr_held", instr, held_instr);
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        NPCOp      = 2'd0;
        Imm16      = '0;
        Imm26      = '0;
        RD1        = '0;
        advance    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        cur_pc     = RST_PC;
        #12;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_PC", PC, RST_PC);
        check("rst_PC4", PC4, RST_PC + 32'd4);
        check("rst_instr", instr, 32'd0);
        check("rst_fetch_tmo", {31'b0, fetch_tmo}, 32'd0);
`ifdef IFETCH_ALIGN_CHK_EN
        check("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
        exp_q.push_back(RST_PC);
        force_fast = 1'b1;
        resp_en    = 1'b1;
        mon_en     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RST_PC);
        @(negedge clk);
        check("first_valid_latency", {31'b0, instr_valid}, 32'd1);
        check("first_PC4", PC4, 32'h0000_3004);
        force_stall = 1'b1;
        drv_en      = 1'b1;

        n = 0;
        while (fetches_done < 60 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("fetch_progress", 32'(fetches_done >= 60), 32'd1);

        // Reset while a request is outstanding; a late ready must not produce a valid.
        @(negedge clk);
        drv_en  = 1'b0;
        resp_en = 1'b0;
        mon_en  = 1'b0;
        #1;
        advance    = 1'b0;
        imem_ready = 1'b0;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            advance = instr_valid;
            n++;
        end
        advance = 1'b0;
        check("reach_req", {31'b0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 check("req_async_drop", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
        rst        = 1'b0;
        #1;
        check("post_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("post_rst_PC", PC, RST_PC);
        check("post_rst_instr", instr, 32'd0);
`ifdef IFETCH_ALIGN_CHK_EN
        check("post_rst_misalign", {31'b0, misalign}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", {31'b0, instr_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
